// File: rtl/base64_pkg.sv
// base64_pkg: shared types, constants and the Base64 character map used by
// base64_stream_encoder.
package base64_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 6;

    // Encoder control states: collect bytes, emit group chars, line break
    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_EMIT = 2'd1,
        ST_CR   = 2'd2,
        ST_LF   = 2'd3
    } state_e;

    localparam logic [BYTE_W-1:0] CHAR_CR  = 8'h0D;
    localparam logic [BYTE_W-1:0] CHAR_LF  = 8'h0A;
    localparam logic [BYTE_W-1:0] CHAR_PAD = 8'h3D;

    // 6-bit index to ASCII; url_safe swaps '+'/'/' for '-'/'_'
    function automatic logic [BYTE_W-1:0] b64_char(input logic [IDX_W-1:0] idx,
                                                   input logic url_safe);
        logic [BYTE_W-1:0] c;
        c = 8'h00;
        if (idx < 6'd26) begin
            c = BYTE_W'(idx) + 8'h41;          // 'A'
        end else if (idx < 6'd52) begin
            c = BYTE_W'(idx) + 8'd71;          // 'a' - 26
        end else if (idx < 6'd62) begin
            c = BYTE_W'(idx) - 8'd4;           // '0' - 52
        end else if (idx == 6'd62) begin
            c = url_safe ? 8'h2D : 8'h2B;
        end else begin
            c = url_safe ? 8'h5F : 8'h2F;
        end
        return c;
    endfunction

endpackage

// File: rtl/base64_stream_encoder.sv
// base64_stream_encoder: streaming Base64 encoder with optional padding and
// CR/LF line wrapping.
// Ports:
//   clk, rst                     - clock, async active-high reset
//   in_data/in_valid/in_last     - input byte stream, in_ready back
//   out_data/out_valid/out_last  - encoded ASCII stream (registered), out_ready back
module base64_stream_encoder
    import base64_pkg::*;
#(
    parameter bit          URL_SAFE = 1'b0,
    parameter bit          PAD_EN   = 1'b1,
    parameter int unsigned MAX_LINE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready
);

    localparam int unsigned LCNT_W = (MAX_LINE > 0) ? $clog2(MAX_LINE + 1) : 1;

    state_e              state_q, state_d;
    logic [BYTE_W-1:0]   byte0_q, byte0_d, byte1_q, byte1_d, byte2_q, byte2_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [1:0]          nbytes_q, nbytes_d;
    logic                msg_end_q, msg_end_d;
    logic [2:0]          cidx_q, cidx_d;
    logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
    logic                out_valid_q, out_valid_d;
    logic [BYTE_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;

    logic [LCNT_W-1:0]   lcnt_inc;
    logic                grp_end, is_final, wrap;

    // Index of the last character emitted for a group of nb bytes
    function automatic logic [2:0] last_idx(input logic [1:0] nb);
        return PAD_EN ? 3'd3 : 3'(nb);
    endfunction

    // Character at position ci of the group; bytes past nb read as zero
    function automatic logic [BYTE_W-1:0] group_char(input logic [BYTE_W-1:0] b0,
                                                     input logic [BYTE_W-1:0] b1,
                                                     input logic [BYTE_W-1:0] b2,
                                                     input logic [1:0]        nb,
                                                     input logic [2:0]        ci);
        logic [23:0]      w;
        logic [IDX_W-1:0] idx;
        w = {b0, (nb >= 2'd2) ? b1 : 8'h00, (nb == 2'd3) ? b2 : 8'h00};
        case (ci)
            3'd0:    idx = w[23:18];
            3'd1:    idx = w[17:12];
            3'd2:    idx = w[11:6];
            default: idx = w[5:0];
        endcase
        return (ci > 3'(nb)) ? CHAR_PAD : b64_char(idx, URL_SAFE);
    endfunction

    // Next-state and next-output decode
    always_comb begin
        state_d    = state_q;
        byte0_d    = byte0_q;
        byte1_d    = byte1_q;
        byte2_d    = byte2_q;
        bcnt_d     = bcnt_q;
        nbytes_d   = nbytes_q;
        msg_end_d  = msg_end_q;
        cidx_d     = cidx_q;
        lcnt_d     = lcnt_q;

        lcnt_inc = lcnt_q + LCNT_W'(1);
        grp_end  = (cidx_q == last_idx(nbytes_q));
        is_final = msg_end_q && grp_end;
        wrap     = (MAX_LINE != 0) && (lcnt_inc == LCNT_W'(MAX_LINE));

        case (state_q)
            ST_ACC: begin
                if (in_valid) begin
                    case (bcnt_q)
                        2'd0:    byte0_d = in_data;
                        2'd1:    byte1_d = in_data;
                        default: byte2_d = in_data;
                    endcase
                    bcnt_d = bcnt_q + 2'd1;
                    if ((bcnt_q == 2'd2) || in_last) begin
                        state_d   = ST_EMIT;
                        nbytes_d  = bcnt_q + 2'd1;
                        msg_end_d = in_last;
                        cidx_d    = 3'd0;
                        bcnt_d    = 2'd0;
                    end
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    lcnt_d = lcnt_inc;
                    cidx_d = cidx_q + 3'd1;
                    if (is_final) begin
                        state_d = ST_ACC;
                        cidx_d  = 3'd0;
                        lcnt_d  = '0;
                    end else if (wrap) begin
                        // cidx may now point past the group; LF checks that
                        state_d = ST_CR;
                        lcnt_d  = '0;
                    end else if (grp_end) begin
                        state_d = ST_ACC;
                        cidx_d  = 3'd0;
                    end
                end
            end
            ST_CR: begin
                if (out_ready) begin
                    state_d = ST_LF;
                end
            end
            ST_LF: begin
                if (out_ready) begin
                    if (cidx_q > last_idx(nbytes_q)) begin
                        state_d = ST_ACC;
                        cidx_d  = 3'd0;
                    end else begin
                        state_d = ST_EMIT;
                    end
                end
            end
            default: state_d = ST_ACC;
        endcase

        // Outputs are derived from next state so they register with it
        out_valid_d = (state_d != ST_ACC);
        out_last_d  = (state_d == ST_EMIT) && msg_end_d && (cidx_d == last_idx(nbytes_d));
        case (state_d)
            ST_EMIT: out_data_d = group_char(byte0_d, byte1_d, byte2_d, nbytes_d, cidx_d);
            ST_CR:   out_data_d = CHAR_CR;
            ST_LF:   out_data_d = CHAR_LF;
            default: out_data_d = 8'h00;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACC;
            byte0_q     <= '0;
            byte1_q     <= '0;
            byte2_q     <= '0;
            bcnt_q      <= '0;
            nbytes_q    <= '0;
            msg_end_q   <= 1'b0;
            cidx_q      <= '0;
            lcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte0_q     <= byte0_d;
            byte1_q     <= byte1_d;
            byte2_q     <= byte2_d;
            bcnt_q      <= bcnt_d;
            nbytes_q    <= nbytes_d;
            msg_end_q   <= msg_end_d;
            cidx_q      <= cidx_d;
            lcnt_q      <= lcnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // Held low during reset so nothing is accepted before the encoder is live
    assign in_ready  = (state_q == ST_ACC) && !rst;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_base64_stream_encoder.sv
// tb_base64_stream_encoder: drives four encoder configurations with directed
// and random messages and checks the character stream against a reference.
module tb_base64_stream_encoder;

    localparam int NDUT = 4;

    typedef logic [7:0] byte_q_t[$];
    typedef logic [8:0] exp_q_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data   [NDUT];
    logic       in_valid  [NDUT];
    logic       in_last   [NDUT];
    logic       in_ready  [NDUT];
    logic [7:0] out_data  [NDUT];
    logic       out_valid [NDUT];
    logic       out_last  [NDUT];
    logic       out_ready [NDUT];

    // Configuration of each instance, mirrored for the reference model
    bit url_cfg  [NDUT] = '{1'b0, 1'b0, 1'b1, 1'b0};
    bit pad_cfg  [NDUT] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int line_cfg [NDUT] = '{0, 0, 0, 4};

    int n_tests = 0;
    int n_fail  = 0;
    int last_cyc;

    byte_q_t stim_b;
    bit      stim_l[$];
    exp_q_t  stim_e;

    always #5 clk = ~clk;

    base64_stream_encoder #(.URL_SAFE(1'b0), .PAD_EN(1'b1), .MAX_LINE(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .in_data(in_data[0]), .in_valid(in_valid[0]), .in_last(in_last[0]), .in_ready(in_ready[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_last(out_last[0]), .out_ready(out_ready[0]));

    base64_stream_encoder #(.URL_SAFE(1'b0), .PAD_EN(1'b0), .MAX_LINE(0)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_data(in_data[1]), .in_valid(in_valid[1]), .in_last(in_last[1]), .in_ready(in_ready[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_last(out_last[1]), .out_ready(out_ready[1]));

    base64_stream_encoder #(.URL_SAFE(1'b1), .PAD_EN(1'b1), .MAX_LINE(0)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_data(in_data[2]), .in_valid(in_valid[2]), .in_last(in_last[2]), .in_ready(in_ready[2]),
        .out_data(out_data[2]), .out_valid(out_valid[2]), .out_last(out_last[2]), .out_ready(out_ready[2]));

    base64_stream_encoder #(.URL_SAFE(1'b0), .PAD_EN(1'b1), .MAX_LINE(4)) u_dut3 (
        .clk(clk), .rst(rst),
        .in_data(in_data[3]), .in_valid(in_valid[3]), .in_last(in_last[3]), .in_ready(in_ready[3]),
        .out_data(out_data[3]), .out_valid(out_valid[3]), .out_last(out_last[3]), .out_ready(out_ready[3]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void clear_stim();
        stim_b.delete();
        stim_l.delete();
        stim_e.delete();
    endfunction

    // Queue one message of bytes, in_last on its final byte
    function automatic void add_bytes(input byte_q_t m);
        foreach (m[i]) begin
            stim_b.push_back(m[i]);
            stim_l.push_back(i == m.size() - 1);
        end
    endfunction

    function automatic byte_q_t str_bytes(input string s);
        byte_q_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
        return q;
    endfunction

    // Literal expected stream; out_last on its final character
    function automatic void add_exp(input string s);
        for (int i = 0; i < s.len(); i++)
            stim_e.push_back({i == s.len() - 1, 8'(s[i])});
    endfunction

    // Reference Base64 encoding of one message for instance k
    function automatic void add_model(input int k, input byte_q_t m);
        string      alpha = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789";
        logic [7:0] dq[$];
        int         n = m.size();
        for (int g = 0; g < n; g += 3) begin
            int nb = (n - g >= 3) ? 3 : n - g;
            int v  = (int'(m[g]) << 16)
                   | ((nb > 1) ? (int'(m[g+1]) << 8) : 0)
                   | ((nb > 2) ? int'(m[g+2]) : 0);
            for (int i = 0; i < 4; i++) begin
                int id = (v >> (18 - 6 * i)) & 63;
                if (i <= nb) begin
                    if (id < 62)       dq.push_back(8'(alpha[id]));
                    else if (id == 62) dq.push_back(url_cfg[k] ? 8'h2D : 8'h2B);
                    else               dq.push_back(url_cfg[k] ? 8'h5F : 8'h2F);
                end else if (pad_cfg[k]) begin
                    dq.push_back(8'h3D);
                end
            end
        end
        foreach (dq[i]) begin
            stim_e.push_back({i == dq.size() - 1, dq[i]});
            if (line_cfg[k] > 0 && (i + 1) % line_cfg[k] == 0 && i != dq.size() - 1) begin
                stim_e.push_back({1'b0, 8'h0D});
                stim_e.push_back({1'b0, 8'h0A});
            end
        end
        add_bytes(m);
    endfunction

    // Stream stim_b into instance k and compare every output beat with stim_e
    task automatic run(input int k, input string name, input int vprob, input int rprob);
        int         bi = 0, oi = 0, cyc = 0, gcnt = 0;
        bit         expect_v = 0, hold = 0;
        logic [7:0] hd = 8'h00;
        logic       hl = 1'b0;
        while ((bi < stim_b.size() || oi < stim_e.size()) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (expect_v) check_eq({name, " latency"}, 32'(out_valid[k]), 32'd1);
            if (hold) begin
                check_eq({name, " hold_valid"}, 32'(out_valid[k]), 32'd1);
                check_eq({name, " hold_data"}, 32'(out_data[k]), 32'(hd));
                check_eq({name, " hold_last"}, 32'(out_last[k]), 32'(hl));
            end
            if (out_valid[k]) check_eq({name, " in_ready_during_out"}, 32'(in_ready[k]), 32'd0);

            in_valid[k]  = (bi < stim_b.size()) && ($urandom_range(99) < vprob);
            in_data[k]   = (bi < stim_b.size()) ? stim_b[bi] : 8'h00;
            in_last[k]   = (bi < stim_b.size()) ? stim_l[bi] : 1'b0;
            out_ready[k] = ($urandom_range(99) < rprob);

            expect_v = 0;
            if (in_valid[k] && in_ready[k]) begin
                gcnt++;
                if (gcnt == 3 || stim_l[bi]) begin
                    expect_v = 1;
                    gcnt     = 0;
                end
                bi++;
            end
            hold = out_valid[k] && !out_ready[k];
            hd   = out_data[k];
            hl   = out_last[k];
            if (out_valid[k] && out_ready[k]) begin
                if (oi < stim_e.size()) begin
                    check_eq($sformatf("%s char%0d", name, oi), 32'(out_data[k]), 32'(stim_e[oi][7:0]));
                    check_eq($sformatf("%s last%0d", name, oi), 32'(out_last[k]), 32'(stim_e[oi][8]));
                end else begin
                    check_eq({name, " extra_char"}, 32'(oi), 32'(stim_e.size()));
                end
                oi++;
            end
        end
        check_eq({name, " chars_seen"}, 32'(oi), 32'(stim_e.size()));
        last_cyc = cyc;
        @(negedge clk);
        in_valid[k]  = 1'b0;
        in_last[k]   = 1'b0;
        out_ready[k] = 1'b0;
        check_eq({name, " idle_after"}, 32'(out_valid[k]), 32'd0);
    endtask

    initial begin
        byte_q_t    m;
        string      man = "Man";
        int         bi;

        for (int k = 0; k < NDUT; k++) begin
            in_valid[k] = 1'b0; in_data[k] = 8'h00; in_last[k] = 1'b0; out_ready[k] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check_eq($sformatf("rst out_valid%0d", k), 32'(out_valid[k]), 32'd0);
            check_eq($sformatf("rst out_data%0d", k), 32'(out_data[k]), 32'd0);
            check_eq($sformatf("rst out_last%0d", k), 32'(out_last[k]), 32'd0);
            check_eq($sformatf("rst in_ready%0d", k), 32'(in_ready[k]), 32'd0);
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++)
            check_eq($sformatf("post_rst in_ready%0d", k), 32'(in_ready[k]), 32'd1);

        // Directed: padding, no-pad, alphabets, wrapping, throughput
        clear_stim(); add_bytes(str_bytes("Man")); add_exp("TWFu");  run(0, "man", 100, 100);
        clear_stim(); add_bytes(str_bytes("Ma"));  add_exp("TWE=");  run(0, "ma", 100, 100);
        clear_stim(); add_bytes(str_bytes("M"));   add_exp("TQ==");  run(0, "m", 100, 100);
        clear_stim(); add_bytes(str_bytes("Man")); add_bytes(str_bytes("Man"));
        add_exp("TWFu"); add_exp("TWFu"); run(0, "thru", 100, 100);
        check_eq("throughput_cycles", 32'(last_cyc), 32'd14);
        clear_stim(); add_bytes(str_bytes("M"));   add_exp("TQ");    run(1, "nopad_m", 100, 100);
        clear_stim(); add_bytes(str_bytes("Ma"));  add_exp("TWE");   run(1, "nopad_ma", 100, 100);
        m.delete(); m.push_back(8'hFB); m.push_back(8'hFF);
        clear_stim(); add_bytes(m); add_exp("+/8="); run(0, "std_alpha", 100, 100);
        clear_stim(); add_bytes(m); add_exp("-_8="); run(2, "url_alpha", 100, 100);
        clear_stim(); add_bytes(str_bytes("ManMan")); add_exp("TWFu\015\012TWFu");
        run(3, "wrap", 100, 100);

        // Backpressure on the first character, then reset during EMIT
        out_ready[0] = 1'b0;
        bi = 0;
        for (int c = 0; c < 20 && !out_valid[0]; c++) begin
            in_valid[0] = (bi < 3);
            in_data[0]  = (bi < 3) ? 8'(man[bi]) : 8'h00;
            in_last[0]  = (bi == 2);
            if (in_valid[0] && in_ready[0]) bi++;
            @(negedge clk);
        end
        in_valid[0] = 1'b0;
        in_last[0]  = 1'b0;
        check_eq("bp out_valid", 32'(out_valid[0]), 32'd1);
        for (int c = 0; c < 5; c++) begin
            check_eq("bp out_data", 32'(out_data[0]), 32'h54);
            check_eq("bp in_ready", 32'(in_ready[0]), 32'd0);
            @(negedge clk);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("midrst out_valid", 32'(out_valid[0]), 32'd0);
        check_eq("midrst out_data", 32'(out_data[0]), 32'd0);
        check_eq("midrst out_last", 32'(out_last[0]), 32'd0);
        check_eq("midrst in_ready", 32'(in_ready[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_stim(); add_bytes(str_bytes("M")); add_exp("TQ=="); run(0, "after_rst", 100, 100);

        // Random messages, random valid/ready, back-to-back within a stream
        for (int k = 0; k < NDUT; k++) begin
            for (int r = 0; r < 3; r++) begin
                clear_stim();
                for (int j = 0; j < 4; j++) begin
                    int len = 1 + $urandom_range(9);
                    m.delete();
                    for (int b = 0; b < len; b++) m.push_back(8'($urandom));
                    add_model(k, m);
                end
                run(k, $sformatf("rnd%0d_%0d", k, r), 70, 60);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/base64_stream_encoder.md
# base64_stream_encoder

Streaming Base64 encoder for the UART-to-IoT transmit path. It accepts a byte stream with valid/ready handshake and per-message `last`, and packs bytes into 3-byte groups. It emits the encoded ASCII characters one per beat with handshake, `=` padding and optional CR/LF line wrapping. Downstream is the UART framer, which sends encoded payloads to the IoT platform.

## Interface
- `URL_SAFE`, default 0: 0 selects the standard alphabet (`+`, `/`); 1 selects the URL-safe alphabet (`-`, `_`).
- `PAD_EN`, default 1: 1 appends `=` to complete a 4-char group; 0 drops the pad characters.
- `MAX_LINE`, default 0: 0 disables wrapping; N>0 inserts CR (0x0D) then LF (0x0A) after every N data characters, never after the final character of a message.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_data` in 8: payload byte.
- `in_valid` in 1: byte present.
- `in_last` in 1: byte is the final byte of the message; qualified by `in_valid`.
- `in_ready` out 1: encoder accepts a byte this cycle.
- `out_data` out 8: ASCII character.
- `out_valid` out 1: character present.
- `out_last` out 1: final character of the encoded message.
- `out_ready` in 1: downstream accepts the character.

## Operation
- States:
  - ACC: collect bytes.
  - EMIT: output group characters.
  - CR, LF: line break.
- ACC:
  - `in_ready`=1.
  - A byte transfers when `in_valid && in_ready`; it is stored in `buf[bcnt]` and `bcnt` increments.
  - When `bcnt` reaches 3, or a transfer carries `in_last`, go to EMIT. Latch `nbytes` (1..3) and `msg_end` = `in_last`.
- Group encoding:
  - 24-bit word = {buf0, buf1, buf2}, with unused bytes zero.
  - Four 6-bit indices come from bits [23:18], [17:12], [11:6], [5:0].
  - Real character count = `nbytes`+1.
  - Characters in positions `nbytes`+1..3 are `=` if `PAD_EN`, otherwise skipped.
- EMIT:
  - `out_valid`=1 and `out_data`=char[`cidx`].
  - On `out_ready`:
    - `cidx` advances and `lcnt` increments.
    - If `MAX_LINE`≠0, `lcnt`==`MAX_LINE` and the character is not the message's last, go to CR and clear `lcnt`.
    - After the group's final emitted character, go to ACC and clear `bcnt`/`cidx`.
- CR/LF:
  - Present 0x0D, then 0x0A, each held until `out_ready`.
  - Then resume EMIT at the next `cidx`, or go to ACC if the group is finished.
- `out_last`=1 only with the final emitted character of a group that has `msg_end`. After that transfer, `lcnt` clears to 0.
- Alphabet: 0–25 `A`–`Z`, 26–51 `a`–`z`, 52–61 `0`–`9`, 62/63 per `URL_SAFE`. Mapping is combinational; no ROM and no extra latency.
- `in_valid` without `in_last` after a message starts a new message. There is no idle gap requirement.

## Timing
- Reset values:
  - State ACC; `bcnt`, `cidx`, `lcnt` = 0.
  - `out_valid`=0, `out_last`=0, `out_data`=0x00.
  - `in_ready`=0 while `rst` is high, and 1 in the first cycle after deassertion.
- Latency: the cycle after the group-completing byte transfers, `out_valid`=1 with the first character.
- `in_ready`=0 throughout EMIT/CR/LF; input and output never overlap.
- Peak throughput with `out_ready` held high and no wrapping: 3 bytes accepted + 4 chars emitted per 7 cycles.
- While `out_valid && !out_ready`, `out_data` and `out_last` hold stable. `out_valid` never drops without a transfer.
- `out_valid`, `out_data` and `out_last` are registered outputs. `in_ready` is decoded from state only and does not depend on `out_ready`.
- Reset mid-message (any state) discards buffered bytes and partial groups. The next output starts a fresh group with `lcnt`=0.

## Structure
- `base64_pkg` holds:
  - the state enum;
  - `CHAR_CR`, `CHAR_LF`, `CHAR_PAD` constants;
  - function `b64_char(idx[5:0], url_safe)` returning 8 bits.
- Single module; no sub-module. The character map is the package function.

## Test plan
- Defaults; send "Man" (0x4D 0x61 0x6E, `last` on 0x6E) -> `TWFu`, `out_last` on `u`; first char valid 1 cycle after the 0x6E transfer.
- Send "Ma" -> `TWE=`; "M" -> `TQ==`; `out_last` on the final `=`.
- `PAD_EN`=0; "M" -> `TQ` with `out_last` on `Q`; "Ma" -> `TWE`.
- `URL_SAFE`=0 vs 1; bytes 0xFB 0xFF -> `+/8=` vs `-_8=`.
- `MAX_LINE`=4; "ManMan" -> `TWFu` 0x0D 0x0A `TWFu`; no CR/LF after the final `u`; `out_last` on it.
- Backpressure and reset:
  - Hold `out_ready` low 5 cycles mid-group: `out_data` stable, `in_ready`=0.
  - Assert `rst` during EMIT of "Man": outputs clear immediately.
  - Then send "M" -> `TQ==`.
